// File: rtl/dm_gpr_access.sv
// ---------------------------------------------------------------------------
// dm_gpr_access
//
// Debug-module access path to the core general purpose register file.
// The module accepts one GPR read/write command at a time. It halts the core,
// waits for the halt to be acknowledged (bounded by HALT_TIMEOUT), performs
// a single-cycle access through the register file debug port, and then holds
// the response until the requester consumes it.
//
// Optional feature (macro DM_AUTOINC_EN):
//   Adds cmd_autoinc_i. When it is high, the target address comes from an
//   internal pointer instead of cmd_addr_i. After every successful access
//   the pointer moves to the next register, wrapping from 31 to 1 and never
//   pointing at x0. A timed-out command leaves the pointer unchanged.
//
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   cmd_valid_i/ready_o   command handshake
//   cmd_we_i              1 = write, 0 = read
//   cmd_addr_i            target GPR index
//   cmd_wdata_i           write data
//   cmd_autoinc_i         (DM_AUTOINC_EN only) use the internal pointer
//   rsp_valid_o/ready_i   response handshake
//   rsp_rdata_o           read data (0 for writes and errors)
//   rsp_err_o             halt timeout, no access performed
//   halt_req_o            core halt request
//   halted_i              core halted acknowledge
//   jtag_en_o/addr_o/data_o  register file debug write port
//   jtag_data_i           register file combinational debug read data
// ---------------------------------------------------------------------------
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef REG_DATA_BUS
`define REG_DATA_BUS 31:0
`endif

module dm_gpr_access #(
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [`REG_ADDR_BUS] cmd_addr_i,
    input  logic [`REG_DATA_BUS] cmd_wdata_i,
`ifdef DM_AUTOINC_EN
    input  logic                 cmd_autoinc_i,
`endif
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [`REG_DATA_BUS] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 halt_req_o,
    input  logic                 halted_i,
    output logic                 jtag_en_o,
    output logic [`REG_ADDR_BUS] jtag_addr_o,
    output logic [`REG_DATA_BUS] jtag_data_o,
    input  logic [`REG_DATA_BUS] jtag_data_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HALT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [31:0]            r_cnt;
    logic                   r_we;
    logic [`REG_ADDR_BUS]   r_addr;
    logic [`REG_DATA_BUS]   r_wdata;
    logic [`REG_DATA_BUS]   r_rdata;
    logic                   r_err;
    logic                   w_timeout;

    assign w_timeout = (r_cnt == HALT_TIMEOUT);

`ifdef DM_AUTOINC_EN
    localparam logic [`REG_ADDR_BUS] ADDR_ONE = 1;
    localparam logic [`REG_ADDR_BUS] ADDR_MAX = '1;

    logic [`REG_ADDR_BUS] r_ptr;
    logic [`REG_ADDR_BUS] w_ptr_next;
    logic [`REG_ADDR_BUS] w_cmd_addr;

    // Next register after the one just accessed; x0 is never a target.
    assign w_ptr_next = (r_addr == ADDR_MAX) ? ADDR_ONE : (r_addr + ADDR_ONE);
    assign w_cmd_addr = cmd_autoinc_i ? r_ptr : cmd_addr_i;
`else
    logic [`REG_ADDR_BUS] w_cmd_addr;
    assign w_cmd_addr = cmd_addr_i;
`endif

    // State register and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
`ifdef DM_AUTOINC_EN
            r_ptr   <= ADDR_ONE;
`endif
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_we    <= cmd_we_i;
                        r_addr  <= w_cmd_addr;
                        r_wdata <= cmd_wdata_i;
                        r_cnt   <= '0;
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (!halted_i) begin
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                end
                S_ACCESS: begin
                    // Read data from the file is combinational, so it is
                    // captured at the edge that closes the access cycle.
                    if (!r_we) begin
                        r_rdata <= jtag_data_i;
                    end
`ifdef DM_AUTOINC_EN
                    r_ptr <= w_ptr_next;
`endif
                end
                default: ;
            endcase
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        cmd_ready_o  = 1'b0;
        halt_req_o   = 1'b0;
        rsp_valid_o  = 1'b0;
        jtag_en_o    = 1'b0;
        jtag_addr_o  = '0;
        jtag_data_o  = '0;
        case (r_state)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    w_state_next = S_HALT;
                end
            end
            S_HALT: begin
                halt_req_o = 1'b1;
                if (halted_i) begin
                    w_state_next = S_ACCESS;
                end else if (w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_ACCESS: begin
                halt_req_o   = 1'b1;
                jtag_addr_o  = r_addr;
                if (r_we) begin
                    jtag_en_o   = 1'b1;
                    jtag_data_o = r_wdata;
                end
                w_state_next = S_RESP;
            end
            S_RESP: begin
                halt_req_o  = 1'b1;
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

endmodule

// File: doc/dm_gpr_access.md
DM_GPR_ACCESS -- requirements
Module: dm_gpr_access

Interface
REQ-001 Parameter: HALT_TIMEOUT, default 255, maximum cycles to wait for halted_i before failing a command.
REQ-002 clk_i  input  1  single clock; all state changes on posedge.
REQ-003 rst_n_i  input  1  reset, synchronous, active-low.
REQ-004 cmd_valid_i  input  1  debug command request.
REQ-005 cmd_ready_o  output  1  command accepted when valid and ready are both high.
REQ-006 cmd_we_i  input  1  1 = GPR write, 0 = GPR read.
REQ-007 cmd_addr_i  input  `REG_ADDR_BUS  target GPR index.
REQ-008 cmd_wdata_i  input  `REG_DATA_BUS  write data.
REQ-009 rsp_valid_o  output  1  response available.
REQ-010 rsp_ready_i  input  1  response consumed when valid and ready are both high.
REQ-011 rsp_rdata_o  output  `REG_DATA_BUS  read data, 0 for writes and errors.
REQ-012 rsp_err_o  output  1  1 = halt timeout, no GPR access performed.
REQ-013 halt_req_o  output  1  core halt request.
REQ-014 halted_i  input  1  core halted, so no core GPR write is pending.
REQ-015 jtag_en_o, jtag_addr_o, jtag_data_o  output  1 / `REG_ADDR_BUS / `REG_DATA_BUS  GPR-file debug write port.
REQ-016 jtag_data_i  input  `REG_DATA_BUS  GPR-file combinational debug read data.

Function
REQ-017 FSM states IDLE, HALT, ACCESS, RESP; one-hot or binary encoding is free.
REQ-018 IDLE: cmd_ready_o=1; on handshake, latch we/addr/wdata, clear timeout counter, go to HALT.
REQ-019 HALT: halt_req_o=1; halted_i=1 -> ACCESS; otherwise increment counter; counter==HALT_TIMEOUT -> RESP with err=1.
REQ-020 ACCESS: lasts exactly one cycle; jtag_addr_o=latched addr; for a write, jtag_en_o=1 and jtag_data_o=latched wdata; for a read, jtag_en_o=0 and jtag_data_i is captured into rsp_rdata_o at the closing edge; next state is RESP.
REQ-021 Outside ACCESS, jtag_en_o=0, jtag_addr_o=0 and jtag_data_o=0.
REQ-022 RESP: rsp_valid_o=1, with rdata/err held stable until rsp_ready_i=1; then go to IDLE.
REQ-023 halt_req_o=1 in HALT, ACCESS and RESP; 0 in IDLE.
REQ-024 cmd_ready_o=0 in all states except IDLE; only one command is outstanding.
REQ-025 Minimum latency: accept at cycle N with halted_i already 1 -> ACCESS at N+2, rsp_valid_o at N+3.
REQ-026 Address 0: a write completes with err=0 and no GPR change (the file ignores x0); a read returns 0.
REQ-027 halted_i dropping during ACCESS or RESP does not abort the command.
REQ-028 HALT_TIMEOUT=0: the HALT state fails on its first cycle unless halted_i=1 in that cycle.

Reset
REQ-029 rst_n_i=0 at a posedge -> state IDLE, counter 0, latched fields 0, rsp_rdata_o=0, rsp_err_o=0, rsp_valid_o=0, halt_req_o=0, jtag_en_o=0.
REQ-030 Reset mid-command drops the command without producing a response; a write interrupted in ACCESS may or may not land.

Configuration
REQ-031 Macro DM_AUTOINC_EN defined: add input cmd_autoinc_i (1 bit); with cmd_autoinc_i=1, the target address is an internal pointer instead of cmd_addr_i.
REQ-032 The pointer loads to cmd_addr_i+1 after every successful non-autoinc access and increments after every successful autoinc access.
REQ-033 The pointer wraps from 31 to 1, skipping x0, and resets to 1.
REQ-034 A timed-out command leaves the pointer unchanged.
REQ-035 DM_AUTOINC_EN undefined: the port and pointer are absent and cmd_addr_i is always used.

Verification
REQ-036 halted_i=1; write addr 5, data 0xDEADBEEF -> ACCESS at N+2 with jtag_en_o=1 and jtag_addr_o=5; rsp at N+3 with err=0; a subsequent read of 5 returns 0xDEADBEEF.
REQ-037 halted_i rises 10 cycles after accept -> exactly one jtag_en_o pulse, after the rise; halt_req_o held until the response is consumed.
REQ-038 HALT_TIMEOUT=4, halted_i=0 -> rsp_err_o=1, rsp_rdata_o=0, jtag_en_o never asserted.
REQ-039 rsp_ready_i held low 5 cycles -> rsp_valid_o and data stable for 5 cycles; cmd_ready_o=0 throughout.
REQ-040 Reset in HALT -> next cycle IDLE, halt_req_o=0, no response.
REQ-041 DM_AUTOINC_EN: write addr 30, then three autoinc writes -> targets 31, 1, 2.
